wave_lookup: RTL and testbench

- Consumer end of the phase accumulator's phase/valid/ready stream.
- Converts each accepted 24-bit phase word into one offset-binary DAC sample: sine from a quarter-wave ROM, or square, triangle or sawtooth.
- Drives the sample stream toward the DAC/PWM stage with its own valid/ready handshake.
- Sits between phase_accum and the DAC driver in the synth datapath at 125 MHz.

---
 rtl/wave_pkg.sv | 35 +++
 rtl/sine_rom.sv | 41 ++++
 rtl/wave_lookup.sv | 221 ++++++++++++++++++++++
 tb/tb_wave_lookup.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wave_pkg.sv
// Shared constants, waveform encoding and quarter-wave sine table generator for wave_lookup.
// WAVE_INTERP_EN (defined by the build) selects the interpolating sine datapath.
package wave_pkg;

  localparam int PHASE_W   = 24;
  localparam int SAMPLE_W  = 12;
  localparam int LUT_AW    = 8;
  localparam int MAG_W     = SAMPLE_W - 1;
  localparam int FRAC_W    = 4;
  localparam int ROM_DEPTH = 1 << LUT_AW;
  localparam int AMPLITUDE = (1 << (SAMPLE_W - 1)) - 1;

  localparam logic [SAMPLE_W-1:0] MIDSCALE = SAMPLE_W'(1 << (SAMPLE_W - 1));

  localparam int BASE_LATENCY   = 2;
  localparam int INTERP_LATENCY = 3;

  typedef enum logic [1:0] {
    WAVE_SINE   = 2'd0,
    WAVE_SQUARE = 2'd1,
    WAVE_TRI    = 2'd2,
    WAVE_SAW    = 2'd3
  } wave_e;

  localparam real PI = 3.14159265358979323846;

  // Entry i holds round(A*sin(2*pi*(i+0.5)/(4*ROM_DEPTH))); the half-step offset keeps
  // the quarter wave symmetric so the mirrored quadrants need no special end cases.
  function automatic logic [MAG_W-1:0] sine_entry(input int i);
    real ang;
    ang = 2.0 * PI * (real'(i) + 0.5) / real'(4 * ROM_DEPTH);
    return MAG_W'($rtoi(real'(AMPLITUDE) * $sin(ang) + 0.5));
  endfunction

endpackage

// File: rtl/sine_rom.sv
// Quarter-wave sine magnitude ROM with registered read, held while en_i is low.
// A second read port exists when WAVE_INTERP_EN is defined.
module sine_rom
  import wave_pkg::*;
(
  input  logic              clk_i,
  input  logic              en_i,
  input  logic [LUT_AW-1:0] addr_a_i,
  output logic [MAG_W-1:0]  data_a_o
`ifdef WAVE_INTERP_EN
  ,
  input  logic [LUT_AW-1:0] addr_b_i,
  output logic [MAG_W-1:0]  data_b_o
`endif
);

  logic [MAG_W-1:0] rom [ROM_DEPTH];

  for (genvar g = 0; g < ROM_DEPTH; g++) begin : g_rom
    assign rom[g] = sine_entry(g);
  end

  logic [MAG_W-1:0] data_a_q;

  always_ff @(posedge clk_i) begin
    if (en_i) data_a_q <= rom[addr_a_i];
  end

  assign data_a_o = data_a_q;

`ifdef WAVE_INTERP_EN
  logic [MAG_W-1:0] data_b_q;

  always_ff @(posedge clk_i) begin
    if (en_i) data_b_q <= rom[addr_b_i];
  end

  assign data_b_o = data_b_q;
`endif

endmodule

// File: rtl/wave_lookup.sv
// Phase word to offset-binary DAC sample (sine/square/triangle/saw) as one stall pipeline.
// Define WAVE_INTERP_EN for linearly interpolated sine (one extra stage, latency 3).
module wave_lookup
  import wave_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic [PHASE_W-1:0]  phase,
  input  logic                phase_valid,
  output logic                phase_ready,
  input  logic [1:0]          wave_sel,
  input  logic                clear,
  output logic [SAMPLE_W-1:0] sample,
  output logic                sample_valid,
  input  logic                sample_ready
);

  // Both streams transfer on a rising edge where valid & ready are high; valid never
  // depends on ready, and the output holds sample/sample_valid until it is taken.
  logic                en;
  logic                take;
  logic                sample_valid_q;
  logic [SAMPLE_W-1:0] sample_q;
  logic [SAMPLE_W-1:0] sample_d;
  logic                tail_valid;
  logic [SAMPLE_W-1:0] tail_sample;

  assign en          = ~sample_valid_q | sample_ready;
  assign phase_ready = en & ~clear;
  assign take        = phase_valid & phase_ready;

  logic                unused_phase;
  assign unused_phase = ^phase[PHASE_W-SAMPLE_W-2:0];

  logic [1:0]          quad_a;
  logic [LUT_AW-1:0]   idx_a;
  logic [LUT_AW-1:0]   addr_a;
  logic [MAG_W-1:0]    mag_a;
  logic [SAMPLE_W-1:0] shape_d;

  assign quad_a = phase[PHASE_W-1 -: 2];
  assign idx_a  = phase[PHASE_W-3 -: LUT_AW];
  assign addr_a = quad_a[0] ? ~idx_a : idx_a;

  always_comb begin
    shape_d = phase[PHASE_W-1 -: SAMPLE_W];
    case (wave_e'(wave_sel))
      WAVE_SQUARE: shape_d = phase[PHASE_W-1] ? '0 : '1;
      WAVE_TRI:    shape_d = phase[PHASE_W-1] ? ~phase[PHASE_W-2 -: SAMPLE_W]
                                              : phase[PHASE_W-2 -: SAMPLE_W];
      default:     shape_d = phase[PHASE_W-1 -: SAMPLE_W];
    endcase
  end

  // Stage 1: ROM read plus the fields later stages need.
  logic                s1_valid_q;
  wave_e               s1_sel_q;
  logic                s1_neg_a_q;
  logic [SAMPLE_W-1:0] s1_shape_q;
  logic signed [SAMPLE_W-1:0] sig_a;

`ifdef WAVE_INTERP_EN
  // Neighbour k+1 wraps across quadrant boundaries and from the last full-wave index to 0.
  logic [LUT_AW+1:0]   k_b;
  logic [1:0]          quad_b;
  logic [LUT_AW-1:0]   idx_b;
  logic [LUT_AW-1:0]   addr_b;
  logic [MAG_W-1:0]    mag_b;
  logic                s1_neg_b_q;
  logic [FRAC_W-1:0]   s1_frac_q;
  logic signed [SAMPLE_W-1:0] sig_b;

  assign k_b    = phase[PHASE_W-1 -: LUT_AW+2] + (LUT_AW+2)'(1);
  assign quad_b = k_b[LUT_AW+1 -: 2];
  assign idx_b  = k_b[LUT_AW-1:0];
  assign addr_b = quad_b[0] ? ~idx_b : idx_b;

  sine_rom u_rom (
    .clk_i    (clk),
    .en_i     (en),
    .addr_a_i (addr_a),
    .data_a_o (mag_a),
    .addr_b_i (addr_b),
    .data_b_o (mag_b)
  );

  assign sig_b = s1_neg_b_q ? -$signed({1'b0, mag_b}) : $signed({1'b0, mag_b});
`else
  sine_rom u_rom (
    .clk_i    (clk),
    .en_i     (en),
    .addr_a_i (addr_a),
    .data_a_o (mag_a)
  );
`endif

  assign sig_a = s1_neg_a_q ? -$signed({1'b0, mag_a}) : $signed({1'b0, mag_a});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_sel_q   <= WAVE_SINE;
      s1_neg_a_q <= 1'b0;
      s1_shape_q <= '0;
`ifdef WAVE_INTERP_EN
      s1_neg_b_q <= 1'b0;
      s1_frac_q  <= '0;
`endif
    end else if (en) begin
      s1_sel_q   <= wave_e'(wave_sel);
      s1_neg_a_q <= quad_a[1];
      s1_shape_q <= shape_d;
`ifdef WAVE_INTERP_EN
      s1_neg_b_q <= quad_b[1];
      s1_frac_q  <= phase[PHASE_W-3-LUT_AW -: FRAC_W];
`endif
    end
  end

  logic s2_valid_q;

`ifdef WAVE_INTERP_EN
  // Stage 2 holds the signed neighbours; stage 3 interpolates and applies the offset.
  localparam int PROD_W = SAMPLE_W + FRAC_W + 2;

  wave_e                      s2_sel_q;
  logic signed [SAMPLE_W-1:0] s2_a_q;
  logic signed [SAMPLE_W-1:0] s2_b_q;
  logic [FRAC_W-1:0]          s2_frac_q;
  logic [SAMPLE_W-1:0]        s2_shape_q;
  logic                       s3_valid_q;
  logic [SAMPLE_W-1:0]        s3_sample_q;
  logic [SAMPLE_W-1:0]        s3_sample_d;
  logic signed [PROD_W-1:0]   a_x;
  logic signed [PROD_W-1:0]   b_x;
  logic signed [PROD_W-1:0]   f_x;
  logic signed [PROD_W-1:0]   prod;
  logic signed [PROD_W-1:0]   step;
  logic [SAMPLE_W-1:0]        interp;

  assign a_x    = PROD_W'(s2_a_q);
  assign b_x    = PROD_W'(s2_b_q);
  assign f_x    = PROD_W'({1'b0, s2_frac_q});
  assign prod   = (b_x - a_x) * f_x;
  assign step   = prod >>> FRAC_W;
  assign interp = s2_a_q + step[SAMPLE_W-1:0];

  assign s3_sample_d = (s2_sel_q == WAVE_SINE) ? MIDSCALE + interp : s2_shape_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_sel_q    <= WAVE_SINE;
      s2_a_q      <= '0;
      s2_b_q      <= '0;
      s2_frac_q   <= '0;
      s2_shape_q  <= '0;
      s3_sample_q <= '0;
    end else if (en) begin
      s2_sel_q    <= s1_sel_q;
      s2_a_q      <= sig_a;
      s2_b_q      <= sig_b;
      s2_frac_q   <= s1_frac_q;
      s2_shape_q  <= s1_shape_q;
      s3_sample_q <= s3_sample_d;
    end
  end

  assign tail_valid  = s3_valid_q;
  assign tail_sample = s3_sample_q;
`else
  logic [SAMPLE_W-1:0] s2_sample_q;
  logic [SAMPLE_W-1:0] s2_sample_d;

  assign s2_sample_d = (s1_sel_q == WAVE_SINE) ? MIDSCALE + sig_a : s1_shape_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_sample_q <= '0;
    end else if (en) begin
      s2_sample_q <= s2_sample_d;
    end
  end

  assign tail_valid  = s2_valid_q;
  assign tail_sample = s2_sample_q;
`endif

  assign sample_d = tail_valid ? tail_sample : sample_q;

  // clear outranks both the input transfer and a pending output handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q     <= 1'b0;
      s2_valid_q     <= 1'b0;
`ifdef WAVE_INTERP_EN
      s3_valid_q     <= 1'b0;
`endif
      sample_valid_q <= 1'b0;
      sample_q       <= MIDSCALE;
    end else if (clear) begin
      s1_valid_q     <= 1'b0;
      s2_valid_q     <= 1'b0;
`ifdef WAVE_INTERP_EN
      s3_valid_q     <= 1'b0;
`endif
      sample_valid_q <= 1'b0;
      sample_q       <= MIDSCALE;
    end else if (en) begin
      s1_valid_q     <= take;
      s2_valid_q     <= s1_valid_q;
`ifdef WAVE_INTERP_EN
      s3_valid_q     <= s2_valid_q;
`endif
      sample_valid_q <= tail_valid;
      sample_q       <= sample_d;
    end
  end

  assign sample       = sample_q;
  assign sample_valid = sample_valid_q;

endmodule

// File: tb/tb_wave_lookup.sv
// Bench for wave_lookup: directed literal cases, backpressure, clear, async reset and a
// randomized stream scored against a trig-based model of the sample rules.
`timescale 1ns/1ps
module tb_wave_lookup;

`ifdef WAVE_INTERP_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [23:0] phase = '0;
  logic        phase_valid = 1'b0;
  logic        phase_ready;
  logic [1:0]  wave_sel = '0;
  logic        clear = 1'b0;
  logic [11:0] sample;
  logic        sample_valid;
  logic        sample_ready = 1'b1;

  int errors = 0;
  int checks = 0;
  int n_out  = 0;
  logic [11:0] exp_q[$];

  wave_lookup dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .phase        (phase),
    .phase_valid  (phase_valid),
    .phase_ready  (phase_ready),
    .wave_sel     (wave_sel),
    .clear        (clear),
    .sample       (sample),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready)
  );

  // ---------------- clock / watchdog ----------------
  always #4 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic int full_wave(input int k);
    real v;
    v = 2047.0 * $sin(2.0 * 3.14159265358979323846 * (real'(k) + 0.5) / 1024.0);
    return (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(-v + 0.5);
  endfunction

  function automatic logic [11:0] model(input logic [23:0] p, input logic [1:0] sel);
    int k;
    k = int'(p[23:14]);
    case (sel)
      2'd0: begin
`ifdef WAVE_INTERP_EN
        int a, b, f, d;
        a = full_wave(k);
        b = full_wave((k + 1) % 1024);
        f = int'(p[13:10]);
        d = (b - a) * f;
        return 12'(2048 + a + ((d >= 0) ? d / 16 : -((-d + 15) / 16)));
`else
        return 12'(2048 + full_wave(k));
`endif
      end
      2'd1:    return p[23] ? 12'd0 : 12'd4095;
      2'd2:    return p[23] ? 12'(4095 - int'(p[22:11])) : p[22:11];
      default: return 12'(p >> 12);
    endcase
  endfunction

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // ---------------- scoreboard / compare process ----------------
  logic        prev_stall = 1'b0;
  logic [11:0] prev_sample = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", sample_valid, 1);
        check("hold_sample", sample, prev_sample);
      end
      if (clear) begin
        exp_q.delete();
      end else begin
        if (sample_valid && sample_ready) begin
          n_out++;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_sample: got 0x%0h expected no sample outstanding", sample);
          end else begin
            check("stream_sample", sample, exp_q.pop_front());
          end
        end
        if (phase_valid && phase_ready) exp_q.push_back(model(phase, wave_sel));
      end
      prev_stall  = sample_valid && !sample_ready && !clear;
      prev_sample = sample;
    end
  end

  // ---------------- driver tasks ----------------
  // All drivers start and end at posedge+1.
  task automatic send(input logic [23:0] p, input logic [1:0] sel);
    int budget;
    budget = 200;
    phase = p;
    wave_sel = sel;
    phase_valid = 1'b1;
    #1;
    while (!phase_ready && budget > 0) begin
      @(posedge clk); #2;
      budget--;
    end
    if (!phase_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got phase_ready=0 expected acceptance within 200 cycles");
      @(posedge clk); #1;
      phase_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    phase_valid = 1'b0;
  endtask

  task automatic directed(input string name, input logic [23:0] p, input logic [1:0] sel,
                          input logic [11:0] exp);
    phase = p;
    wave_sel = sel;
    phase_valid = 1'b1;
    sample_ready = 1'b1;
    #1;
    check({name, "_ready"}, phase_ready, 1);
    @(posedge clk); #1;
    phase_valid = 1'b0;
    for (int i = 1; i < LAT; i++) begin
      @(posedge clk); #1;
    end
    check({name, "_early"}, sample_valid, 0);
    @(posedge clk); #1;
    check({name, "_valid"}, sample_valid, 1);
    check(name, sample, exp);
  endtask

  task automatic drain(input string name);
    int b;
    b = 0;
    while ((exp_q.size() != 0 || sample_valid || phase_valid) && b < 200) begin
      @(posedge clk); #2;
      b++;
    end
    check({name, "_drained"}, exp_q.size(), 0);
    @(posedge clk); #1;
  endtask

  logic [23:0] edge_words[5] = '{24'hFFFFFF, 24'h3FFFFF, 24'h7FFC00, 24'hBFFFFF, 24'h000000};

  // ---------------- main sequence ----------------
  initial begin
    int n0;

    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_sample", sample, 2048);
    check("rst_valid", sample_valid, 0);
    check("rst_ready", phase_ready, 1);
    #2 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("idle_sample", sample, 2048);
    check("idle_valid", sample_valid, 0);
    check("idle_ready", phase_ready, 1);

    directed("sine_q1", 24'h400000, 2'd0, 12'd4095);
    directed("sine_q3", 24'hC00000, 2'd0, 12'd1);
    directed("sine_zero", 24'h000000, 2'd0, 12'd2054);
    directed("sine_half", 24'h800000, 2'd0, 12'd2042);
    directed("saw", 24'h123456, 2'd3, 12'h123);
    directed("tri_c0", 24'hC00000, 2'd2, 12'h7FF);
    directed("tri_top", 24'h7FFFFF, 2'd2, 12'hFFF);
    directed("square_hi", 24'h7FFFFF, 2'd1, 12'd4095);
    directed("square_lo", 24'h800000, 2'd1, 12'd0);
    @(posedge clk); #1;

    // Backpressure: four saw words against a stalled sink.
    n0 = n_out;
    sample_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 4; i++) send(24'((i + 1) << 20), 2'd3);
      end
    join_none
    repeat (LAT + 1) @(posedge clk);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #2;
      check("bp_ready_low", phase_ready, 0);
      check("bp_valid", sample_valid, 1);
      check("bp_hold", sample, 12'h100);
    end
    @(posedge clk); #1;
    sample_ready = 1'b1;
    drain("bp");
    check("bp_count", n_out - n0, 4);

    // clear with two words in flight and a third offered.
    n0 = n_out;
    send(24'h400000, 2'd0);
    send(24'h123456, 2'd3);
    phase = 24'h555555;
    wave_sel = 2'd0;
    phase_valid = 1'b1;
    clear = 1'b1;
    #1;
    check("clr_ready", phase_ready, 0);
    @(posedge clk); #1;
    clear = 1'b0;
    phase_valid = 1'b0;
    check("clr_valid", sample_valid, 0);
    check("clr_sample", sample, 2048);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #2;
      check("clr_no_stale", sample_valid, 0);
    end
    check("clr_count", n_out - n0, 0);
    @(posedge clk); #1;

    // Randomized stream with edge phases, stalls and occasional clear.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 7) == 0) phase = edge_words[$urandom_range(0, 4)];
      else phase = 24'($urandom);
      wave_sel = 2'($urandom_range(0, 3));
      phase_valid = ($urandom_range(0, 3) != 0);
      sample_ready = ($urandom_range(0, 3) != 0);
      clear = ($urandom_range(0, 59) == 0);
      @(posedge clk); #1;
    end
    clear = 1'b0;
    phase_valid = 1'b0;
    sample_ready = 1'b1;
    drain("rand");

    // Asynchronous reset pulse mid-stream, between edges.
    for (int i = 0; i < 4; i++) begin
      phase = 24'($urandom);
      wave_sel = 2'd0;
      phase_valid = 1'b1;
      @(posedge clk); #1;
    end
    phase_valid = 1'b0;
    check("pre_rst_valid", sample_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_sample", sample, 2048);
    check("arst_valid", sample_valid, 0);
    check("arst_ready", phase_ready, 1);
    @(negedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    directed("post_rst_sine", 24'h400000, 2'd0, 12'd4095);
    directed("post_rst_saw", 24'hABCDEF, 2'd3, 12'hABC);
    drain("final");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
